// File: rtl/axil_slave_read_bridge_if.sv
// Bundles the AXI4-Lite read channels and the user-side request/data port
// so that the bridge and its environment share one set of wires.
interface axil_slave_read_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  S_AXIL_ARVALID;
    logic                  S_AXIL_ARREADY;
    logic [ADDR_WIDTH-1:0] S_AXIL_ARADDR;
    logic [2:0]            S_AXIL_ARPROT;
    logic                  S_AXIL_RVALID;
    logic                  S_AXIL_RREADY;
    logic [DATA_WIDTH-1:0] S_AXIL_RDATA;
    logic [1:0]            S_AXIL_RRESP;

    logic                  user_port_arvalid;
    logic                  user_port_arready;
    logic [ADDR_WIDTH-1:0] user_port_araddr;
    logic [2:0]            user_port_arprot;
    logic                  user_port_rready;
    logic                  user_port_rvalid;
    logic [DATA_WIDTH-1:0] user_port_rdata;
    logic [1:0]            user_port_rresp;

    // Bridge view: AXI slave on one side, request master toward the peripheral.
    modport slave (
        input  S_AXIL_ARVALID, S_AXIL_ARADDR, S_AXIL_ARPROT, S_AXIL_RREADY,
        input  user_port_arready, user_port_rvalid, user_port_rdata, user_port_rresp,
        output S_AXIL_ARREADY, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP,
        output user_port_arvalid, user_port_araddr, user_port_arprot, user_port_rready
    );

    // Environment view: the AXI master plus the peripheral behind the bridge.
    modport master (
        output S_AXIL_ARVALID, S_AXIL_ARADDR, S_AXIL_ARPROT, S_AXIL_RREADY,
        output user_port_arready, user_port_rvalid, user_port_rdata, user_port_rresp,
        input  S_AXIL_ARREADY, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP,
        input  user_port_arvalid, user_port_araddr, user_port_arprot, user_port_rready
    );
endinterface

// File: rtl/axil_slave_read_bridge.sv
// AXI4-Lite read slave bridging one outstanding read to a valid/ready user port,
// with window decode (DECERR), optional privilege check and a user-port watchdog (SLVERR).
module axil_slave_read_bridge #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           SPAN_LOG2      = 12,
    parameter int unsigned           TIMEOUT_CYCLES = 16,
    parameter bit                    REQUIRE_PRIV   = 1'b0
) (
    input  logic                          S_AXIL_ACLK,
    input  logic                          S_AXIL_ARESETn,
    axil_slave_read_bridge_if.slave       bus,
    output logic [7:0]                    timeout_count
);

    localparam int unsigned BYTE_LSB = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((ADDR_WIDTH'(1) << BYTE_LSB) - ADDR_WIDTH'(1));
    localparam int unsigned WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_LIMIT =
        WD_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, RESP} state_t;

    typedef struct packed {
        logic                  arready;
        logic                  rvalid;
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            rresp;
        logic                  uarvalid;
        logic                  urready;
        logic [ADDR_WIDTH-1:0] uaraddr;
        logic [2:0]            uarprot;
        logic [WD_WIDTH-1:0]   wd_cnt;
        logic [7:0]            to_cnt;
    } regs_t;

    state_t                state_q, state_d;
    regs_t                 q, d;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_window;
    logic                  priv_ok;
    logic                  wd_expired;
    logic [WD_WIDTH-1:0]   wd_next;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets.
    assign offset     = bus.S_AXIL_ARADDR - BASE_ADDR;
    assign in_window  = (offset >> SPAN_LOG2) == '0;
    assign priv_ok    = !REQUIRE_PRIV || bus.S_AXIL_ARPROT[0];
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (q.wd_cnt == WD_LIMIT);
    // Saturates at the limit so a late channel handshake keeps the watchdog expired.
    assign wd_next    = wd_expired ? q.wd_cnt : q.wd_cnt + WD_WIDTH'(1);

    function automatic regs_t abort_regs(input regs_t r);
        regs_t o;
        o        = r;
        o.rvalid = 1'b1;
        o.rresp  = RESP_SLVERR;
        o.rdata  = '0;
        o.to_cnt = (r.to_cnt == 8'hFF) ? r.to_cnt : r.to_cnt + 8'd1;
        return o;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first (d = q), so no
        // path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        d          = q;
        d.arready  = 1'b0;
        d.uarvalid = 1'b0;
        d.urready  = 1'b0;

        unique case (state_q)
            IDLE: begin
                d.arready = 1'b1;
                if (bus.S_AXIL_ARVALID && q.arready) begin
                    d.arready = 1'b0;
                    d.uaraddr = offset & ALIGN_MASK;
                    d.uarprot = bus.S_AXIL_ARPROT;
                    if (!in_window) begin
                        state_d = RESP;
                        d.rvalid = 1'b1;
                        d.rresp  = RESP_DECERR;
                        d.rdata  = '0;
                    end else if (!priv_ok) begin
                        state_d = RESP;
                        d.rvalid = 1'b1;
                        d.rresp  = RESP_SLVERR;
                        d.rdata  = '0;
                    end else begin
                        state_d    = REQ;
                        d.uarvalid = 1'b1;
                        d.wd_cnt   = '0;
                    end
                end
            end
            REQ: begin
                if (bus.user_port_arready) begin
                    state_d   = WAIT_DATA;
                    d.urready = 1'b1;
                    d.wd_cnt  = wd_next;
                end else if (wd_expired) begin
                    state_d = RESP;
                    d       = abort_regs(d);
                end else begin
                    d.uarvalid = 1'b1;
                    d.wd_cnt   = wd_next;
                end
            end
            WAIT_DATA: begin
                if (bus.user_port_rvalid) begin
                    state_d  = RESP;
                    d.rvalid = 1'b1;
                    d.rdata  = bus.user_port_rdata;
                    d.rresp  = bus.user_port_rresp;
                end else if (wd_expired) begin
                    state_d = RESP;
                    d       = abort_regs(d);
                end else begin
                    d.urready = 1'b1;
                    d.wd_cnt  = wd_next;
                end
            end
            RESP: begin
                if (bus.S_AXIL_RREADY) begin
                    state_d   = IDLE;
                    d.rvalid  = 1'b0;
                    d.arready = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXIL_ACLK or negedge S_AXIL_ARESETn) begin
        if (!S_AXIL_ARESETn) begin
            state_q <= IDLE;
            q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            q       <= d;
        end
    end

    assign bus.S_AXIL_ARREADY    = q.arready;
    assign bus.S_AXIL_RVALID     = q.rvalid;
    assign bus.S_AXIL_RDATA      = q.rdata;
    assign bus.S_AXIL_RRESP      = q.rresp;
    assign bus.user_port_arvalid = q.uarvalid;
    assign bus.user_port_rready  = q.urready;
    assign bus.user_port_araddr  = q.uaraddr;
    assign bus.user_port_arprot  = q.uarprot;
    assign timeout_count         = q.to_cnt;

endmodule

// File: tb/tb_axil_slave_read_bridge.sv
// Randomised scoreboard bench for axil_slave_read_bridge: a driver issues reads and
// predicts each response, a peripheral model answers with chosen delays, a monitor checks.
module tb_axil_slave_read_bridge;

    localparam int unsigned    AW        = 32;
    localparam int unsigned    DW        = 32;
    localparam logic [AW-1:0]  BASE      = '0;
    localparam int unsigned    SPAN_LOG2 = 12;
    localparam int             TMO       = 16;
    localparam bit             PRIV      = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] timeout_count;
    int         cyc = 0;

    axil_slave_read_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_slave_read_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .SPAN_LOG2(SPAN_LOG2),
        .TIMEOUT_CYCLES(TMO), .REQUIRE_PRIV(PRIV)
    ) dut (
        .S_AXIL_ACLK(clk),
        .S_AXIL_ARESETn(rst_n),
        .bus(bus),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        int            lat;
        int            hs;
        bit            is_to;
    } exp_t;

    typedef struct {
        logic [AW-1:0] off;
        logic [2:0]    prot;
        int            a;
        int            d;
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } per_t;

    exp_t exp_q[$];
    per_t per_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_timeouts = 0;
    int   rready_hold = 0;
    bit   in_resp = 1'b0;
    per_t p_cur;
    int   p_ph = 0;
    int   p_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: outcome and latency (cycles from AR handshake edge to RVALID)
    // derived from the decode rules and the peripheral's chosen delays.
    function automatic exp_t predict(input logic [AW-1:0] addr, input logic [2:0] prot,
                                     input int a, input int dly, input logic [DW-1:0] pdata,
                                     input logic [1:0] presp, output bit to_periph);
        exp_t          e;
        logic [AW-1:0] off;
        int            last, first_wait, abort_at;
        off = addr - BASE;
        e.hs = 0; e.is_to = 1'b0; to_periph = 1'b0;
        if (off >= (AW'(1) << SPAN_LOG2)) begin
            e.data = '0; e.resp = 2'b11; e.lat = 1;
        end else if (PRIV && !prot[0]) begin
            e.data = '0; e.resp = 2'b10; e.lat = 1;
        end else begin
            to_periph  = 1'b1;
            last       = TMO - 1;
            first_wait = a + 1;
            // The watchdog fires in the first cycle at/after the limit with no handshake.
            if (a > last) abort_at = last;
            else if (a + 1 + dly <= ((first_wait > last) ? first_wait : last)) abort_at = -1;
            else abort_at = (first_wait > last) ? first_wait : last;
            if (abort_at < 0) begin
                e.data = pdata; e.resp = presp; e.lat = a + 1 + dly + 2;
            end else begin
                e.data = '0; e.resp = 2'b10; e.lat = abort_at + 2; e.is_to = 1'b1;
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the AR handshake.
    task automatic do_read(input logic [AW-1:0] addr, input logic [2:0] prot, input int a,
                           input int dly, input logic [DW-1:0] pdata, input logic [1:0] presp);
        exp_t e;
        per_t p;
        bit   to_periph;
        int   n = 0;
        e = predict(addr, prot, a, dly, pdata, presp, to_periph);
        bus.S_AXIL_ARVALID = 1'b1;
        bus.S_AXIL_ARADDR  = addr;
        bus.S_AXIL_ARPROT  = prot;
        while (!bus.S_AXIL_ARREADY) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                $display("FAIL arready_wait: got 0x0 expected 0x1 (cycle %0d)", cyc);
                $fatal(1, "ARREADY never asserted");
            end
        end
        if (to_periph) begin
            p.off = (addr - BASE) & ~AW'(DW / 8 - 1);
            p.prot = prot; p.a = a; p.d = dly; p.data = pdata; p.resp = presp;
            per_q.push_back(p);
        end
        e.hs = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.S_AXIL_ARVALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, 64'(bus.S_AXIL_ARREADY), 64'd0);
        check({tag, "_rvalid"}, 64'(bus.S_AXIL_RVALID), 64'd0);
        check({tag, "_rdata"}, 64'(bus.S_AXIL_RDATA), 64'd0);
        check({tag, "_rresp"}, 64'(bus.S_AXIL_RRESP), 64'd0);
        check({tag, "_u_arvalid"}, 64'(bus.user_port_arvalid), 64'd0);
        check({tag, "_u_rready"}, 64'(bus.user_port_rready), 64'd0);
        check({tag, "_u_araddr"}, 64'(bus.user_port_araddr), 64'd0);
        check({tag, "_u_arprot"}, 64'(bus.user_port_arprot), 64'd0);
        check({tag, "_timeout_count"}, 64'(timeout_count), 64'd0);
    endtask

    // Release just after a posedge, then ARREADY must be 0 for one cycle and 1 after.
    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arready_first_cycle", 64'(bus.S_AXIL_ARREADY), 64'd0);
        @(negedge clk);
        check("arready_second_cycle", 64'(bus.S_AXIL_ARREADY), 64'd1);
    endtask

    // RREADY: random backpressure, or forced low for rready_hold RVALID cycles.
    initial begin
        bus.S_AXIL_RREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) bus.S_AXIL_RREADY = 1'b0;
            else if (rready_hold > 0) begin
                bus.S_AXIL_RREADY = 1'b0;
                if (bus.S_AXIL_RVALID) rready_hold--;
            end else bus.S_AXIL_RREADY = ($urandom_range(0, 3) != 0);
        end
    end

    // Peripheral model: accepts after a REQ cycles, returns data after d rready cycles,
    // and pulses a late rvalid after an abort to prove it is ignored.
    initial begin
        bus.user_port_arready = 1'b0;
        bus.user_port_rvalid  = 1'b0;
        bus.user_port_rdata   = '0;
        bus.user_port_rresp   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ph = 0;
                per_q.delete();
                bus.user_port_arready = 1'b0;
                bus.user_port_rvalid  = 1'b0;
            end else begin
                case (p_ph)
                    0: if (bus.user_port_arvalid) begin
                        if (per_q.size() == 0) begin
                            check("user_req_unexpected", 64'(bus.user_port_arvalid), 64'd0);
                        end else begin
                            p_cur = per_q.pop_front();
                            check("user_araddr", 64'(bus.user_port_araddr), 64'(p_cur.off));
                            check("user_arprot", 64'(bus.user_port_arprot), 64'(p_cur.prot));
                            p_idx = 0;
                            bus.user_port_arready = (p_cur.a == 0);
                            p_ph = 1;
                        end
                    end
                    1: if (!bus.user_port_arvalid) begin
                        if (bus.user_port_arready) begin
                            check("user_rready_after_ar", 64'(bus.user_port_rready), 64'd1);
                            p_idx = 0;
                            p_ph  = 2;
                            bus.user_port_rvalid = (p_cur.d == 0);
                            bus.user_port_rdata  = p_cur.data;
                            bus.user_port_rresp  = p_cur.resp;
                        end else p_ph = 0;
                        bus.user_port_arready = 1'b0;
                    end else begin
                        p_idx++;
                        bus.user_port_arready = (p_idx >= p_cur.a);
                    end
                    2: if (!bus.user_port_rready) begin
                        if (bus.user_port_rvalid) begin
                            bus.user_port_rvalid = 1'b0;
                            p_ph = 0;
                        end else begin
                            bus.user_port_rvalid = 1'b1;
                            bus.user_port_rdata  = DW'($urandom);
                            bus.user_port_rresp  = 2'b00;
                            p_ph = 3;
                        end
                    end else begin
                        p_idx++;
                        bus.user_port_rvalid = (p_idx >= p_cur.d);
                    end
                    default: begin
                        bus.user_port_rvalid = 1'b0;
                        p_ph = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: compares every RVALID cycle against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) in_resp = 1'b0;
            else if (bus.S_AXIL_RVALID) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_without_request", 64'(bus.S_AXIL_RVALID), 64'd0);
                end else begin
                    if (!in_resp) begin
                        in_resp = 1'b1;
                        check("rvalid_latency", 64'(cyc - exp_q[0].hs), 64'(exp_q[0].lat));
                    end
                    check("rdata", 64'(bus.S_AXIL_RDATA), 64'(exp_q[0].data));
                    check("rresp", 64'(bus.S_AXIL_RRESP), 64'(exp_q[0].resp));
                    check("arready_low_in_resp", 64'(bus.S_AXIL_ARREADY), 64'd0);
                    if (bus.S_AXIL_RREADY) begin
                        if (exp_q[0].is_to && exp_timeouts < 255) exp_timeouts++;
                        void'(exp_q.pop_front());
                        in_resp = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int n;
        bus.S_AXIL_ARVALID = 1'b0;
        bus.S_AXIL_ARADDR  = '0;
        bus.S_AXIL_ARPROT  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        // Directed reads.
        do_read(32'h0000_0010, 3'b001, 0, 0, 32'hDEAD_BEEF, 2'b00);
        do_read(32'h0000_2000, 3'b001, 0, 0, 32'h1111_1111, 2'b00);
        do_read(32'h0000_0100, 3'b000, 0, 0, 32'h2222_2222, 2'b00);
        do_read(32'h0000_0104, 3'b001, 1, 2, 32'h3333_3333, 2'b00);
        do_read(32'h0000_0FFF, 3'b011, 0, 0, 32'h4444_4444, 2'b10);
        do_read(32'h0000_1000, 3'b001, 0, 0, 32'h5555_5555, 2'b00);
        drain();

        // Watchdog: abort, terminal-cycle wins, and limits on both channels.
        do_read(32'h0000_0020, 3'b001, 0, 100, 32'h6666_6666, 2'b00);
        drain();
        check("timeout_count_after_abort", 64'(timeout_count), 64'(exp_timeouts));
        do_read(32'h0000_0024, 3'b001, 0, TMO - 2, 32'h7777_7777, 2'b00);
        do_read(32'h0000_0028, 3'b001, 0, TMO - 1, 32'h8888_8888, 2'b00);
        do_read(32'h0000_002C, 3'b001, TMO - 1, 0, 32'h9999_9999, 2'b11);
        do_read(32'h0000_0030, 3'b001, TMO + 2, 0, 32'hAAAA_AAAA, 2'b00);
        drain();
        check("timeout_count_boundaries", 64'(timeout_count), 64'(exp_timeouts));

        // Backpressure on R for five RVALID cycles.
        rready_hold = 5;
        do_read(32'h0000_0040, 3'b101, 0, 0, 32'hBBBB_BBBB, 2'b00);
        drain();

        // Reset while waiting for peripheral data.
        do_read(32'h0000_0044, 3'b001, 0, 60, 32'hCCCC_CCCC, 2'b00);
        n = 0;
        while (!bus.user_port_rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait_data", 64'(bus.user_port_rready), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        exp_q.delete();
        exp_timeouts = 0;
        release_reset();
        do_read(32'h0000_0048, 3'b001, 0, 0, 32'hCAFE_F00D, 2'b00);
        drain();

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] addr;
            int            a, dl;
            case ($urandom_range(0, 9))
                0:       addr = AW'($urandom);
                1:       addr = AW'(32'h0000_1000 + $urandom_range(0, 255));
                default: addr = AW'($urandom_range(0, 4095));
            endcase
            a  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            dl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            do_read(addr, 3'($urandom_range(0, 7)), a, dl, DW'($urandom),
                    2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        check("timeout_count_final", 64'(timeout_count), 64'(exp_timeouts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
